// File: rtl/vga_pkg.sv
// vga_pkg: fetch FSM encoding and 640x480@75 timing defaults shared by the line fetcher
package vga_pkg;
  typedef enum logic [1:0] {IDLE, REQ, DRAIN} fetch_state_t;
  localparam int VGA_H_VISIBLE    = 640;
  localparam int VGA_H_SYNC_START = 656;
  localparam int VGA_H_SYNC_END   = 720;
  localparam int VGA_H_TOTAL      = 840;
  localparam int VGA_V_VISIBLE    = 480;
  localparam int VGA_V_SYNC_START = 481;
  localparam int VGA_V_SYNC_END   = 484;
  localparam int VGA_V_TOTAL      = 500;
  localparam int VGA_PIX_CLK_HZ   = 31_500_000;
  localparam int VGA_DATA_W       = 12;
  localparam logic [VGA_DATA_W-1:0] VGA_UNDER_COLOR = 12'hF00;
endpackage

// File: rtl/vga_line_fetch_if.sv
// vga_line_fetch_if: frame-memory read port, req/ack for addresses and in-order valid for data
interface vga_line_fetch_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 12
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  modport master (output rd_req, rd_addr, input rd_ack, rd_valid, rd_data);
  modport slave  (input rd_req, rd_addr, output rd_ack, rd_valid, rd_data);
endinterface

// File: rtl/vga_line_ram.sv
// vga_line_ram: ping-pong line store with one write port and one registered read port
module vga_line_ram #(
  parameter int DEPTH  = 640,
  parameter int DATA_W = 12,
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              wsel_i,
  input  logic [IW-1:0]     widx_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              rsel_i,
  input  logic [IW-1:0]     ridx_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [2][DEPTH];
  always_ff @(posedge clk) begin
    if (we_i) mem_q[wsel_i][widx_i] <= wdata_i;
    rdata_o <= mem_q[rsel_i][ridx_i];
  end
endmodule

// File: rtl/vga_line_fetch.sv
// vga_line_fetch: prefetches the next visible scanline into a ping-pong buffer and
// emits RGB with syncs/de delayed two cycles to stay aligned with the pixel data.
module vga_line_fetch import vga_pkg::*; #(
  parameter int W         = 12,
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_TOTAL   = VGA_V_TOTAL,
  parameter int DATA_W    = VGA_DATA_W,
  parameter int ADDR_W    = 19,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter logic [DATA_W-1:0] UNDER_COLOR = VGA_UNDER_COLOR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic [W-1:0]      hdata,
  input  logic [W-1:0]      vdata,
  input  logic              de_in,
  vga_line_fetch_if.master  rd,
  output logic [DATA_W-1:0] rgb,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              underrun
);
  localparam int IW = $clog2(H_VISIBLE);
  localparam int CW = $clog2(H_VISIBLE + 1);
  fetch_state_t state_q, state_d;
  logic [W-1:0] vprev_q, nxt;
  logic [CW-1:0] req_cnt_q, req_cnt_d, rsp_cnt_q, rsp_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d, base;
  logic [1:0] valid_q, valid_d, hs_q, vs_q, de_q;
  logic sel_q, sel_d, bv_q, under_q, trig, wr;
  logic [DATA_W-1:0] pix, rgb_q, rgb_d;
  always_comb begin
    nxt = (vdata == W'(V_TOTAL - 1)) ? '0 : vdata + W'(1);
    trig = hdata == '0 && vdata != vprev_q && nxt < W'(V_VISIBLE);
    wr = rd.rd_valid && state_q != IDLE && rsp_cnt_q != CW'(H_VISIBLE);
    base = BASE_ADDR;
    for (int i = 0; i < 32; i++) if (H_VISIBLE[i]) base = base + (ADDR_W'(nxt) << i);
    state_d = state_q;
    sel_d = sel_q;
    req_cnt_d = req_cnt_q;
    rsp_cnt_d = rsp_cnt_q + CW'(wr);
    addr_d = addr_q;
    valid_d = valid_q;
    if (state_q == IDLE && trig) begin
      state_d = REQ;
      sel_d = nxt[0];
      req_cnt_d = '0;
      rsp_cnt_d = '0;
      addr_d = base;
      valid_d[nxt[0]] = 1'b0;
    end
    if (state_q == REQ && rd.rd_ack) begin
      req_cnt_d = req_cnt_q + CW'(1);
      addr_d = addr_q + ADDR_W'(1);
      if (req_cnt_q == CW'(H_VISIBLE - 1)) state_d = DRAIN;
    end
    if (state_q == DRAIN && rsp_cnt_q == CW'(H_VISIBLE)) begin
      valid_d[sel_q] = 1'b1;
      state_d = IDLE;
    end
    rgb_d = de_q[0] ? (bv_q ? pix : UNDER_COLOR) : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q <= 1'b0;
      vprev_q <= '0;
      req_cnt_q <= '0;
      rsp_cnt_q <= '0;
      addr_q <= '0;
      valid_q <= '0;
      hs_q <= '0;
      vs_q <= '0;
      de_q <= '0;
      bv_q <= 1'b0;
      rgb_q <= '0;
      under_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      vprev_q <= vdata;
      req_cnt_q <= req_cnt_d;
      rsp_cnt_q <= rsp_cnt_d;
      addr_q <= addr_d;
      valid_q <= valid_d;
      hs_q <= {hs_q[0], hsync_in};
      vs_q <= {vs_q[0], vsync_in};
      de_q <= {de_q[0], de_in};
      bv_q <= valid_q[vdata[0]];
      rgb_q <= rgb_d;
      under_q <= under_q | (de_q[0] & ~bv_q);
    end
  end
  vga_line_ram #(.DEPTH(H_VISIBLE), .DATA_W(DATA_W)) u_ram (
    .clk(clk), .we_i(wr), .wsel_i(sel_q), .widx_i(IW'(rsp_cnt_q)), .wdata_i(rd.rd_data),
    .rsel_i(vdata[0]), .ridx_i(hdata[IW-1:0]), .rdata_o(pix)
  );
  assign rd.rd_req = state_q == REQ;
  assign rd.rd_addr = addr_q;
  assign rgb = rgb_q;
  assign hsync = hs_q[1];
  assign vsync = vs_q[1];
  assign de = de_q[1];
  assign underrun = under_q;
endmodule

// File: tb/tb_vga_line_fetch.sv
// tb_vga_line_fetch: scaled-down timing (16x6 visible, 160x8 total) against a memory model
// returning addr[11:0], with an expected-picture model computed from line/pixel arithmetic.
module tb_vga_line_fetch;
  localparam int W = 12, HV = 16, VV = 6, VT = 8, HT = 160, DW = 12, AW = 19;
  localparam logic [AW-1:0] BASE = 19'h7FFC0;
  localparam logic [DW-1:0] UNDER = 12'hF00;
  logic clk = 1'b0, rst = 1'b1, hsync_in = 1'b0, vsync_in = 1'b0, de_in = 1'b0;
  logic [W-1:0] hdata = '0, vdata = '0;
  logic [DW-1:0] rgb;
  logic hsync, vsync, de, underrun;
  vga_line_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) rd();
  vga_line_fetch #(.W(W), .H_VISIBLE(HV), .V_VISIBLE(VV), .V_TOTAL(VT), .DATA_W(DW), .ADDR_W(AW),
    .BASE_ADDR(BASE), .UNDER_COLOR(UNDER)) dut (
    .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in), .hdata(hdata), .vdata(vdata),
    .de_in(de_in), .rd(rd), .rgb(rgb), .hsync(hsync), .vsync(vsync), .de(de), .underrun(underrun)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  int hx = 0, vy = 0, cyc = 0, settle = 0;
  logic chk_sync = 1'b0, chk_rgb = 1'b0;
  int lstat [VT];
  int ack_pct = 100, stall_line = -1;
  logic [AW-1:0] rq_addr [$];
  int rq_due [$];
  logic held = 1'b0;
  logic [AW-1:0] held_addr = '0;
  logic [2:0] h0 = '0, h1 = '0;
  int x0 = 0, y0 = 0, x1 = 0, y1 = 0;
  int win_reqs = 0;
  logic got_first = 1'b0;
  logic [AW-1:0] first_addr = '0;

  function automatic logic [DW-1:0] pix(int y, int x);
    logic [AW-1:0] a;
    a = BASE + AW'(y * HV + x);
    return a[DW-1:0];
  endfunction

  task automatic set_lines(int v);
    for (int i = 0; i < VT; i++) lstat[i] = v;
  endtask

  task automatic cycle();
    logic [DW-1:0] e;
    logic a;
    @(negedge clk);
    if (settle > 0) settle--;
    else begin
      if (chk_sync) begin
        checks++;
        if ({de, vsync, hsync} !== h1) begin
          errors++;
          $display("FAIL sync cyc=%0d de/vs/hs got=%b exp=%b", cyc, {de, vsync, hsync}, h1);
        end
      end
      if (chk_rgb && !(h1[2] && lstat[y1] == 2)) begin
        e = !h1[2] ? '0 : (lstat[y1] == 1 ? UNDER : pix(y1, x1));
        checks++;
        if (rgb !== e) begin
          errors++;
          $display("FAIL rgb cyc=%0d x=%0d y=%0d got=%h exp=%h", cyc, x1, y1, rgb, e);
        end
      end
    end
    if (held) begin
      checks++;
      if (rd.rd_req !== 1'b1 || rd.rd_addr !== held_addr) begin
        errors++;
        $display("FAIL hold cyc=%0d req=%b addr=%h exp_addr=%h", cyc, rd.rd_req, rd.rd_addr, held_addr);
      end
    end
    if (rd.rd_req && vy >= VV - 1 && vy <= VT - 2) win_reqs++;
    a = (vy == stall_line) ? 1'b0 : ($urandom_range(99) < ack_pct);
    rd.rd_ack = a;
    if (rd.rd_req && a) begin
      rq_addr.push_back(rd.rd_addr);
      rq_due.push_back(cyc + 3);
      if (vy == VT - 1 && !got_first) begin
        got_first = 1'b1;
        first_addr = rd.rd_addr;
      end
    end
    held = rd.rd_req && !a;
    held_addr = rd.rd_addr;
    if (rq_due.size() > 0 && rq_due[0] == cyc) begin
      rd.rd_valid = 1'b1;
      rd.rd_data = rq_addr[0][DW-1:0];
      void'(rq_addr.pop_front());
      void'(rq_due.pop_front());
    end else begin
      rd.rd_valid = 1'b0;
      rd.rd_data = DW'($urandom);
    end
    h1 = h0; x1 = x0; y1 = y0;
    de_in = hx < HV && vy < VV;
    hsync_in = hx >= HV + 2 && hx < HV + 6;
    vsync_in = vy == VV;
    hdata = W'(hx);
    vdata = W'(vy);
    h0 = {de_in, vsync_in, hsync_in}; x0 = hx; y0 = vy;
    hx++;
    if (hx == HT) begin
      hx = 0;
      vy = (vy == VT - 1) ? 0 : vy + 1;
    end
    cyc++;
  endtask

  task automatic goto_pos(int x, int y);
    for (int n = 0; n < HT * VT + 2 && !(hx == x && vy == y); n++) cycle();
  endtask

  task automatic reset_dut();
    chk_sync = 1'b0; chk_rgb = 1'b0; held = 1'b0;
    rst = 1'b1; hx = HT - 4; vy = VT - 2;
    repeat (3) cycle();
    checks++;
    if ({rgb, hsync, vsync, de, underrun, rd.rd_req, rd.rd_addr} !== '0) begin
      errors++;
      $display("FAIL reset rgb=%h hs=%b vs=%b de=%b under=%b req=%b addr=%h", rgb, hsync, vsync, de,
        underrun, rd.rd_req, rd.rd_addr);
    end
    rst = 1'b0; held = 1'b0; settle = 2; chk_sync = 1'b1;
  endtask

  task automatic check_under(string name, logic exp);
    checks++;
    if (underrun !== exp) begin
      errors++;
      $display("FAIL %s underrun got=%b exp=%b", name, underrun, exp);
    end
  endtask

  task automatic test_reset();
    reset_dut();
  endtask

  task automatic test_steady();
    reset_dut();
    set_lines(0); ack_pct = 100; chk_rgb = 1'b1;
    repeat (2 * HT * VT) cycle();
    goto_pos(10, 5);
    repeat (3) cycle();
    checks++;
    if (rgb !== pix(5, 10)) begin
      errors++;
      $display("FAIL steady_px got=%h exp=%h", rgb, pix(5, 10));
    end
    check_under("steady", 1'b0);
  endtask

  task automatic test_sync();
    chk_rgb = 1'b0;
    repeat (HT * VT) cycle();
    chk_rgb = 1'b1;
  endtask

  task automatic test_backpressure();
    reset_dut();
    set_lines(0); ack_pct = 30; chk_rgb = 1'b1;
    repeat (2 * HT * VT) cycle();
    ack_pct = 100;
    check_under("backpressure", 1'b0);
  endtask

  task automatic test_stall();
    reset_dut();
    set_lines(0); lstat[3] = 1; lstat[4] = 2; chk_rgb = 1'b1;
    goto_pos(0, VT - 1);
    stall_line = 2;
    goto_pos(0, 4);
    check_under("stall_mid", 1'b1);
    goto_pos(0, VT - 1);
    stall_line = -1; set_lines(0);
    repeat (HT * VT) cycle();
    check_under("stall_end", 1'b1);
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    while (rd.rd_req !== 1'b1 && n < 2 * HT) begin
      cycle();
      n++;
    end
    checks++;
    if (rd.rd_req !== 1'b1) begin
      errors++;
      $display("FAIL mid_req_wait got=%b exp=1", rd.rd_req);
    end
    chk_sync = 1'b0; chk_rgb = 1'b0; held = 1'b0;
    rst = 1'b1;
    cycle();
    checks++;
    if ({rd.rd_req, rgb, hsync, vsync, de, underrun} !== '0) begin
      errors++;
      $display("FAIL mid_reset req=%b rgb=%h hs=%b vs=%b de=%b under=%b", rd.rd_req, rgb, hsync, vsync,
        de, underrun);
    end
    reset_dut();
    set_lines(0); chk_rgb = 1'b1;
    repeat (HT * VT + HT) cycle();
    check_under("after_mid_reset", 1'b0);
  endtask

  task automatic test_wrap();
    reset_dut();
    set_lines(0); chk_rgb = 1'b1;
    goto_pos(0, 0);
    win_reqs = 0; got_first = 1'b0;
    goto_pos(0, VV - 1);
    goto_pos(0, 0);
    checks++;
    if (win_reqs != 0) begin
      errors++;
      $display("FAIL wrap_noreq got=%0d exp=0", win_reqs);
    end
    checks++;
    if (!got_first || first_addr !== BASE) begin
      errors++;
      $display("FAIL wrap_base seen=%b addr=%h exp=%h", got_first, first_addr, BASE);
    end
    check_under("wrap", 1'b0);
  endtask

  initial begin
    rd.rd_ack = 1'b0; rd.rd_valid = 1'b0; rd.rd_data = '0;
    set_lines(0);
    test_reset();
    test_steady();
    test_sync();
    test_backpressure();
    test_stall();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
